butterfly_inverse: RTL and testbench

Pipelined inverse radix-2 butterfly for the pitch-detection FFT datapath. It takes the two outputs of a forward butterfly plus the same twiddle and reconstructs the original operand pair: A = (out0+out1)/2 and B = conj(W)·(out0−out1)/2. It is used for the IFFT/resynthesis pass and as a round-trip checker beside the forward butterfly. Three register stages with valid/ready flow control sustain one butterfly per cycle.

---
 rtl/butterfly_inverse.sv | 166 ++++++++++++++++
 tb/tb_butterfly_inverse.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_inverse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : butterfly_inverse
// Description : Pipelined inverse radix-2 butterfly. Takes the two outputs
//               of a forward butterfly (x0 = A+BW, x1 = A-BW) and the same
//               twiddle W, and rebuilds the operand pair:
//                 A = (x0+x1)/2,  B = conj(W)*(x0-x1)/2
//               Three register stages with valid/ready flow control. Bubbles
//               collapse, so the pipe holds up to three sets under a stall.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   input set valid
//               in_ready   block accepts the set this cycle
//               in_x0      forward out0, packed {re, im}, Q1.(HALF-1) halves
//               in_x1      forward out1, packed {re, im}
//               in_w       twiddle used by the forward pass, packed {re, im}
//               in_last    sideband, carried with the data
//               out_valid  output set valid
//               out_ready  downstream accepts
//               out_a      reconstructed A, packed {re, im}
//               out_b      reconstructed B, packed {re, im}
//               out_last   in_last of the same set
// Revision    : 1.0 - initial release
// ============================================================================
module butterfly_inverse #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x0,
  input  logic [WIDTH-1:0] in_x1,
  input  logic [WIDTH-1:0] in_w,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_last
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * HALF;

  // --------------------------------------------------------------------------
  // Flow control: a stage may load whenever the stage below it can move or
  // it is itself empty, which lets bubbles be squeezed out under a stall.
  // --------------------------------------------------------------------------
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3      = out_ready | ~v3;
  assign adv2      = adv3 | ~v2;
  assign adv1      = adv2 | ~v1;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // --------------------------------------------------------------------------
  // Stage 1: sum and difference at HALF+1 bits so nothing wraps, then halve.
  // Dropping bit 0 is the arithmetic shift right by one (floor).
  // --------------------------------------------------------------------------
  logic signed [HALF:0] sum_r, sum_i, dif_r, dif_i;

  assign sum_r = {in_x0[WIDTH-1], in_x0[WIDTH-1:HALF]} + {in_x1[WIDTH-1], in_x1[WIDTH-1:HALF]};
  assign sum_i = {in_x0[HALF-1],  in_x0[HALF-1:0]}     + {in_x1[HALF-1],  in_x1[HALF-1:0]};
  assign dif_r = {in_x0[WIDTH-1], in_x0[WIDTH-1:HALF]} - {in_x1[WIDTH-1], in_x1[WIDTH-1:HALF]};
  assign dif_i = {in_x0[HALF-1],  in_x0[HALF-1:0]}     - {in_x1[HALF-1],  in_x1[HALF-1:0]};

  logic [WIDTH-1:0] s1_a, s1_bw, s1_w;
  logic             s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_a    <= '0;
      s1_bw   <= '0;
      s1_w    <= '0;
      s1_last <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_a    <= {sum_r[HALF:1], sum_i[HALF:1]};
        s1_bw   <= {dif_r[HALF:1], dif_i[HALF:1]};
        s1_w    <= in_w;
        s1_last <= in_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: the four partial products of conj(W) * BW, full precision.
  // --------------------------------------------------------------------------
  logic signed [HALF-1:0] w_r, w_i, bw_r, bw_i;
  logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;

  assign w_r  = s1_w[WIDTH-1:HALF];
  assign w_i  = s1_w[HALF-1:0];
  assign bw_r = s1_bw[WIDTH-1:HALF];
  assign bw_i = s1_bw[HALF-1:0];

  assign p_rr = PW'(w_r) * PW'(bw_r);
  assign p_ii = PW'(w_i) * PW'(bw_i);
  assign p_ri = PW'(w_r) * PW'(bw_i);
  assign p_ir = PW'(w_i) * PW'(bw_r);

  logic [WIDTH-1:0]     s2_a;
  logic signed [PW-1:0] s2_prr, s2_pii, s2_pri, s2_pir;
  logic                 s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_a    <= '0;
      s2_prr  <= '0;
      s2_pii  <= '0;
      s2_pri  <= '0;
      s2_pir  <= '0;
      s2_last <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_a    <= s1_a;
        s2_prr  <= p_rr;
        s2_pii  <= p_ii;
        s2_pri  <= p_ri;
        s2_pir  <= p_ir;
        s2_last <= s1_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: combine products one bit wider, then take the Q1.(HALF-1) slice.
  // The top bits are discarded, so overflow wraps like the forward butterfly.
  // --------------------------------------------------------------------------
  logic signed [PW:0] br_sum, bi_sum;

  assign br_sum = (PW+1)'(s2_prr) + (PW+1)'(s2_pii);
  assign bi_sum = (PW+1)'(s2_pri) - (PW+1)'(s2_pir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3       <= 1'b0;
      out_a    <= '0;
      out_b    <= '0;
      out_last <= 1'b0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        out_a    <= s2_a;
        out_b    <= {br_sum[PW-2:HALF-1], bi_sum[PW-2:HALF-1]};
        out_last <= s2_last;
      end
    end
  end

  // Bits deliberately dropped by the shift and slice operations above.
  logic unused_bits;
  assign unused_bits = ^{sum_r[0], sum_i[0], dif_r[0], dif_i[0],
                         br_sum[PW:PW-1], br_sum[HALF-2:0],
                         bi_sum[PW:PW-1], bi_sum[HALF-2:0]};

endmodule
`default_nettype wire

// File: tb/tb_butterfly_inverse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_butterfly_inverse
// Description : Self-checking bench for butterfly_inverse. Expected outputs
//               come from plain integer arithmetic on each accepted set, held
//               in a FIFO; occupancy of that FIFO predicts in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_inverse;

  localparam int WIDTH = 32;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x0     = '0;
  logic [WIDTH-1:0] in_x1     = '0;
  logic [WIDTH-1:0] in_w      = '0;
  logic             in_last   = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_last;

  butterfly_inverse #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x0     (in_x0),
    .in_x1     (in_x1),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    int          acc;
    bit          rt;
    logic [31:0] oa;
    logic [31:0] ob;
  } exp_t;

  exp_t        q[$];
  int          checks     = 0;
  int          errors     = 0;
  int          cyc        = 0;
  int          out_count  = 0;
  int          ready_mode = 0;
  bit          last_fire  = 1'b0;
  bit          prev_hold  = 1'b0;
  logic [31:0] hold_a     = '0;
  logic [31:0] hold_b     = '0;
  logic        hold_last  = 1'b0;
  bit          cur_rt     = 1'b0;
  logic [31:0] cur_oa     = '0;
  logic [31:0] cur_ob     = '0;

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Inverse butterfly arithmetic straight from the definition.
  function automatic void model(input logic [31:0] x0, input logic [31:0] x1,
                                input logic [31:0] w,
                                output logic [31:0] a, output logic [31:0] b);
    longint x0r, x0i, x1r, x1i, wr, wi, ar, ai, bwr, bwi, br, bi;
    x0r = longint'($signed(x0[31:16]));
    x0i = longint'($signed(x0[15:0]));
    x1r = longint'($signed(x1[31:16]));
    x1i = longint'($signed(x1[15:0]));
    wr  = longint'($signed(w[31:16]));
    wi  = longint'($signed(w[15:0]));
    ar  = (x0r + x1r) >>> 1;
    ai  = (x0i + x1i) >>> 1;
    bwr = (x0r - x1r) >>> 1;
    bwi = (x0i - x1i) >>> 1;
    br  = (wr * bwr + wi * bwi) >>> 15;
    bi  = (wr * bwi - wi * bwr) >>> 15;
    a   = {ar[15:0], ai[15:0]};
    b   = {br[15:0], bi[15:0]};
  endfunction

  // Forward butterfly with rounding: x0 = A + B*W, x1 = A - B*W.
  function automatic void forward(input int ar, input int ai, input int br, input int bi,
                                  input int wr, input int wi,
                                  output logic [31:0] x0, output logic [31:0] x1);
    longint bwr, bwi;
    bwr = (longint'(br) * wr - longint'(bi) * wi + 16384) >>> 15;
    bwi = (longint'(br) * wi + longint'(bi) * wr + 16384) >>> 15;
    x0  = {16'(ar + int'(bwr)), 16'(ai + int'(bwi))};
    x1  = {16'(ar - int'(bwr)), 16'(ai - int'(bwi))};
  endfunction

  function automatic bit within2(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    return (d >= -2) && (d <= 2);
  endfunction

  // Runs at the falling edge: everything seen here is what the next rising
  // edge will act on.
  task automatic monitor();
    exp_t        e;
    int          cnt;
    logic [31:0] ea, eb;
    last_fire = 1'b0;
    if (!rst_n) begin
      q.delete();
      prev_hold = 1'b0;
      return;
    end
    cnt = q.size();
    check(in_ready == (out_ready || cnt < 3), "in_ready",
          64'(in_ready), 64'(out_ready || cnt < 3));
    if (prev_hold)
      check(out_valid && out_a == hold_a && out_b == hold_b && out_last == hold_last,
            "stall_hold", {out_a, out_b}, {hold_a, hold_b});
    if (cnt == 0)
      check(!out_valid, "no_phantom", 64'(out_valid), 64'd0);
    if (out_valid && out_ready && cnt > 0) begin
      e = q.pop_front();
      out_count++;
      check(out_a == e.a, "out_a", 64'(out_a), 64'(e.a));
      check(out_b == e.b, "out_b", 64'(out_b), 64'(e.b));
      check(out_last == e.last, "out_last", 64'(out_last), 64'(e.last));
      check(cyc >= e.acc + 2, "latency", 64'(cyc), 64'(e.acc + 2));
      if (e.rt) begin
        check(out_a == e.oa, "roundtrip_a", 64'(out_a), 64'(e.oa));
        check(within2(out_b[31:16], e.ob[31:16]) && within2(out_b[15:0], e.ob[15:0]),
              "roundtrip_b", 64'(out_b), 64'(e.ob));
      end
    end
    if (in_valid && in_ready) begin
      model(in_x0, in_x1, in_w, ea, eb);
      e.a    = ea;
      e.b    = eb;
      e.last = in_last;
      e.acc  = cyc + 1;
      e.rt   = cur_rt;
      e.oa   = cur_oa;
      e.ob   = cur_ob;
      q.push_back(e);
      last_fire = 1'b1;
    end
    prev_hold = out_valid && !out_ready;
    hold_a    = out_a;
    hold_b    = out_b;
    hold_last = out_last;
  endtask

  // One clock: apply out_ready policy, observe at the falling edge, return
  // 1 ns after the next rising edge.
  task automatic step();
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic present(input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] w, input logic last);
    in_valid = 1'b1;
    in_x0    = x0;
    in_x1    = x1;
    in_w     = w;
    in_last  = last;
    cur_rt   = 1'b0;
  endtask

  task automatic present_random();
    present($urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = last_fire;
    end
    in_valid = 1'b0;
    check(got, "accept", 64'(got), 64'd1);
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) step();
    check(q.size() == 0, "drain", 64'(q.size()), 64'd0);
  endtask

  // Accept, then the set must be visible after the third rising edge
  // counting the accepting one, and not before.
  task automatic directed(input string name, input logic [31:0] ea, input logic [31:0] eb);
    step();
    check(last_fire, {name, "_accept"}, 64'(last_fire), 64'd1);
    in_valid = 1'b0;
    check(!out_valid, {name, "_early1"}, 64'(out_valid), 64'd0);
    step();
    check(!out_valid, {name, "_early2"}, 64'(out_valid), 64'd0);
    step();
    check(out_valid, {name, "_valid"}, 64'(out_valid), 64'd1);
    check(out_a == ea, {name, "_a"}, 64'(out_a), 64'(ea));
    check(out_b == eb, {name, "_b"}, 64'(out_b), 64'(eb));
  endtask

  initial begin
    int          n0, c0, ar, ai, br, bi, wr, wi;
    real         th;
    logic [31:0] x0, x1;

    // Reset state
    #12;
    check(!out_valid && out_a == 0 && out_b == 0 && !out_last, "reset_outputs",
          {out_a, out_b}, 64'd0);
    check(in_ready, "reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unity twiddle
    ready_mode = 1;
    present(32'h2FFF_0000, 32'hF001_0000, 32'h7FFF_0000, 1'b1);
    directed("unity", 32'h1000_0000, 32'h1FFE_0000);
    check(out_last, "unity_last", 64'(out_last), 64'd1);
    drain();

    // Streaming round trip through the forward butterfly
    n0 = out_count;
    c0 = cyc;
    for (int i = 0; i < 64; i++) begin
      ar = int'($urandom_range(0, 8191)) - 4096;
      ai = int'($urandom_range(0, 8191)) - 4096;
      br = int'($urandom_range(0, 4095)) - 2048;
      bi = int'($urandom_range(0, 4095)) - 2048;
      th = real'($urandom_range(0, 65535)) * 6.283185307179586 / 65536.0;
      wr = $rtoi($floor(32767.0 * $cos(th) + 0.5));
      wi = $rtoi($floor(32767.0 * $sin(th) + 0.5));
      forward(ar, ai, br, bi, wr, wi, x0, x1);
      present(x0, x1, {16'(wr), 16'(wi)}, 1'(i % 3 == 0));
      cur_rt = 1'b1;
      cur_oa = {16'(ar), 16'(ai)};
      cur_ob = {16'(br), 16'(bi)};
      wait_accept();
    end
    cur_rt = 1'b0;
    check(cyc - c0 == 64, "stream_accept_rate", 64'(cyc - c0), 64'd64);
    repeat (3) step();
    check(out_count - n0 == 64, "stream_emit_rate", 64'(out_count - n0), 64'd64);
    drain();

    // Backpressure: three fit, the fourth waits
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      present_random();
      wait_accept();
    end
    check(q.size() == 3, "bp_held", 64'(q.size()), 64'd3);
    present_random();
    for (int i = 0; i < 4; i++) begin
      step();
      check(!last_fire && !in_ready, "bp_blocked", 64'(in_ready), 64'd0);
    end
    n0 = out_count;
    ready_mode = 1;
    step();
    check(last_fire, "bp_resume4", 64'(last_fire), 64'd1);
    check(out_count - n0 == 1, "bp_drain1", 64'(out_count - n0), 64'd1);
    present_random();
    step();
    check(last_fire, "bp_resume5", 64'(last_fire), 64'd1);
    check(out_count - n0 == 2, "bp_drain2", 64'(out_count - n0), 64'd2);
    in_valid = 1'b0;
    step();
    check(out_count - n0 == 3, "bp_drain3", 64'(out_count - n0), 64'd3);
    drain();

    // Random valid/ready toggling
    n0 = out_count;
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 2) == 0) step();
      present_random();
      wait_accept();
    end
    drain();
    check(out_count - n0 == 1000, "random_count", 64'(out_count - n0), 64'd1000);

    // Reset with three sets in flight
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      present_random();
      wait_accept();
    end
    #2 rst_n = 1'b0;
    #1;
    check(!out_valid && out_a == 0 && out_b == 0 && !out_last, "rst_mid_outputs",
          {out_a, out_b}, 64'd0);
    check(in_ready, "rst_mid_in_ready", 64'(in_ready), 64'd1);
    step();
    step();
    #2 rst_n = 1'b1;
    n0 = out_count;
    ready_mode = 1;
    present(32'h0000_4000, 32'h0000_C000, 32'h0000_8000, 1'b0);
    directed("minus_j", 32'h0000_0000, 32'hC000_0000);
    repeat (6) step();
    check(out_count - n0 == 1, "rst_only_new", 64'(out_count - n0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
